// File: rtl/comparator_pkg.sv
// Shared encodings for the bit-serial magnitude comparator: FSM states and verdict codes.
package comparator_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] EQ = 2'd0;
    localparam logic [1:0] LT = 2'd1;
    localparam logic [1:0] GT = 2'd2;

endpackage

// File: rtl/bit_compare_cell.sv
// Combinational 1-bit magnitude compare cell, built as 4:1 muxes selected by {a_bit, b_bit}.
module bit_compare_cell (
    input  logic a_bit,
    input  logic b_bit,
    output logic lt,
    output logic gt,
    output logic eq
);

    logic [1:0] sel;
    logic [3:0] lt_tbl;
    logic [3:0] gt_tbl;
    logic [3:0] eq_tbl;

    // Each table is the mux data input; entry i is the answer for {a_bit, b_bit} == i.
    assign sel    = {a_bit, b_bit};
    assign lt_tbl = 4'b0010;
    assign gt_tbl = 4'b0100;
    assign eq_tbl = 4'b1001;

    assign lt = lt_tbl[sel];
    assign gt = gt_tbl[sel];
    assign eq = eq_tbl[sel];

endmodule

// File: rtl/serial_magnitude_comparator_ctrl.sv
// Bit-serial unsigned magnitude comparator: walks latched operands MSB->LSB through one compare cell.
// Optional macro EARLY_EXIT_EN: finish as soon as the first differing bit is seen.
module serial_magnitude_comparator_ctrl
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             decided_q, decided_d;
    logic [1:0]       verdict_q, verdict_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;

    logic cell_lt;
    logic cell_gt;
    logic cell_eq;
    logic first_diff;
    logic last_bit;

    bit_compare_cell u_cell (
        .a_bit (a_q[index_q]),
        .b_bit (b_q[index_q]),
        .lt    (cell_lt),
        .gt    (cell_gt),
        .eq    (cell_eq)
    );

    assign first_diff = !decided_q && !cell_eq;

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        decided_d = decided_q;
        verdict_d = verdict_q;
        a_d       = a_q;
        b_d       = b_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        last_bit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    index_d   = IDX_LAST;
                    decided_d = 1'b0;
                    verdict_d = EQ;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (first_diff) begin
                    decided_d = 1'b1;
                    verdict_d = cell_lt ? LT : GT;
                end
`ifdef EARLY_EXIT_EN
                last_bit = (index_q == '0) || first_diff;
`else
                last_bit = (index_q == '0);
`endif
                // Results are loaded on the way into DONE so they are valid alongside the pulse.
                if (last_bit) begin
                    state_d = DONE;
                    lt_d    = (verdict_d == LT);
                    gt_d    = (verdict_d == GT);
                    eq_d    = !decided_d;
                end else begin
                    index_d = index_q - IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            index_q   <= IDX_LAST;
            decided_q <= 1'b0;
            verdict_q <= EQ;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            decided_q <= decided_d;
            verdict_q <= verdict_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
        end
    end

    // Operand holding registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign lt   = lt_q;
    assign gt   = gt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a timeline model.
module tb_serial_magnitude_comparator_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;

    int compared;
    int mismatched;

    serial_magnitude_comparator_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .gt    (gt),
        .eq    (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Number of SHIFT cycles an operation takes, from the operand values alone.
    function automatic int op_len(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef EARLY_EXIT_EN
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x[i] != y[i]) return WIDTH - i;
        end
`endif
        return WIDTH;
    endfunction

    // Timeline model: what the outputs must show in the cycle after each edge.
    logic m_armed = 1'b0;
    logic m_busy, m_done, m_lt, m_gt, m_eq;
    logic p_lt, p_gt, p_eq;
    int   m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_armed = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_lt    = 1'b0;
            m_gt    = 1'b0;
            m_eq    = 1'b0;
            m_left  = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_lt   = p_lt;
                m_gt   = p_gt;
                m_eq   = p_eq;
            end
        end else if (start) begin
            m_left = op_len(a, b);
            p_lt   = (a < b);
            p_gt   = (a > b);
            p_eq   = (a == b);
            m_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("lt", lt, m_lt);
            check("gt", gt, m_gt);
            check("eq", eq, m_eq);
        end
    end

    // One-cycle start pulse; returns cycles from acceptance to done (cycle k+n).
    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, output int lat);
        int n;
        @(negedge clk);
        a = xa;
        b = xb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_timeout", n, 0);
        end
        lat = n;
    endtask

    initial begin
        int lat;
        int nd;
        int last;
        compared   = 0;
        mismatched = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lt", lt, 0);
        check("rst_gt", gt, 0);
        check("rst_eq", eq, 0);
        rst = 1'b0;

        run_op(8'h5A, 8'h5A, lat);
        check("t1_lat", lat, 9);
        check("t1_eq", eq, 1);
        check("t1_lt", lt, 0);
        check("t1_gt", gt, 0);

        run_op(8'h80, 8'h7F, lat);
`ifdef EARLY_EXIT_EN
        check("t2_lat", lat, 2);
`else
        check("t2_lat", lat, 9);
`endif
        check("t2_gt", gt, 1);
        check("t2_eq", eq, 0);

        run_op(8'h01, 8'h02, lat);
`ifdef EARLY_EXIT_EN
        check("t3_lat", lat, 8);
`else
        check("t3_lat", lat, 9);
`endif
        check("t3_lt", lt, 1);

        // Second start while busy must be dropped.
        @(negedge clk);
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        nd = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            start = (n == 3);
            if (n == 3) begin
                a = 8'hFF;
                b = 8'h00;
            end
            if (done) nd++;
        end
        start = 1'b0;
        check("t4_done_count", nd, 1);
        check("t4_lt", lt, 1);
        check("t4_gt", gt, 0);

        // Reset mid-operation aborts it.
        @(negedge clk);
        a = 8'hF0;
        b = 8'h0F;
        start = 1'b1;
        nd = 0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (n == 4);
            if (done) nd++;
        end
`ifdef EARLY_EXIT_EN
        check("t5_done_count", nd, 1);
`else
        check("t5_done_count", nd, 0);
`endif
        check("t5_busy", busy, 0);
        check("t5_lt", lt, 0);
        check("t5_gt", gt, 0);
        check("t5_eq", eq, 0);
        run_op(8'h0F, 8'h0F, lat);
        check("t5_lat", lat, 9);
        check("t5_eq_after", eq, 1);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h03;
        b = 8'h03;
        start = 1'b1;
        last = -1;
        nd = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) check("t6_period", n - last, 10);
                last = n;
                nd++;
            end
            if (nd > 0) check("t6_eq_stable", eq, 1);
        end
        start = 1'b0;
        check("t6_pulses", nd, 4);
        repeat (12) @(negedge clk);

        // Randomized traffic: model comparison runs every cycle.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 2) == 0);
            a     = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: b = WIDTH'($urandom);
            endcase
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
